// File: rtl/txpybuf_rd.sv
// -----------------------------------------------------------------------------
// txpybuf_rd
//
// Transmit payload buffer reader. When a payload starts, this block builds the
// ACL payload header and fetches 32-bit words from the TX payload buffer over a
// request/acknowledge port. It then serialises the header and the payload data
// LSB-first on bufpacketin. One bit is consumed per bit_adv_p strobe.
//
// Ports
//   clk_6M          system clock, all logic on the rising edge
//   rst             synchronous active-high reset
//   py_st_p         payload start pulse; also restarts a payload in flight
//   bit_adv_p       consume the current bit and present the next one
//   existpyheader   payload carries a header (sampled at py_st_p)
//   BRss            1: 8-bit header with 5-bit length, 0: 16-bit header with
//                   10-bit length (sampled at py_st_p)
//   regi_LLID       header LLID
//   regi_FLOW       header FLOW
//   regi_pylenByte  payload length in bytes
//   txbuf_rd_req    read request, held with txbuf_adr until acknowledged
//   txbuf_adr       buffer word address
//   txbuf_rd_ack    one-cycle acknowledge, txbuf_rdat valid in the same cycle
//   txbuf_rdat      read data, byte 0 in [7:0]
//   bufpacketin     current payload bit
//   tx_busy         header or data is being sent
//   tx_done_p       one-cycle pulse after the last data bit is consumed
//   tx_underrun     sticky flag: a data bit was consumed before its word came
// -----------------------------------------------------------------------------
module txpybuf_rd #(
   parameter int ADR_W  = 8,
   parameter int MAXLEN = 1021
) (
   input  logic             clk_6M,
   input  logic             rst,
   input  logic             py_st_p,
   input  logic             bit_adv_p,
   input  logic             existpyheader,
   input  logic             BRss,
   input  logic [1:0]       regi_LLID,
   input  logic             regi_FLOW,
   input  logic [9:0]       regi_pylenByte,
   output logic             txbuf_rd_req,
   output logic [ADR_W-1:0] txbuf_adr,
   input  logic             txbuf_rd_ack,
   input  logic [31:0]      txbuf_rdat,
   output logic             bufpacketin,
   output logic             tx_busy,
   output logic             tx_done_p,
   output logic             tx_underrun
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_HDR  = 2'd1;
   localparam logic [1:0] S_DATA = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [9:0] MAXLEN_L = 10'(MAXLEN);

   logic [1:0]  state;
   logic [9:0]  len_q;
   logic [12:0] nbits;
   logic [8:0]  nwords;
   logic [15:0] hdr_shift;
   logic [3:0]  hdr_cnt;
   logic        hdr_short;
   logic [31:0] word_shift;
   logic [31:0] prefetch;
   logic        ws_valid;
   logic        pf_valid;
   logic [12:0] bitcnt;
   logic [8:0]  fetched;

   logic [9:0]  st_len;
   logic [8:0]  st_nwords;
   logic [15:0] st_hdr;
   logic        busy;
   logic        adv_data;
   logic [12:0] nb;
   logic [8:0]  nb_word;
   logic        ack_ok;
   logic        want;
   logic        data_last;
   logic [3:0]  hdr_last;

   // Payload length and header as they will be latched on a start pulse.
   // Basic-rate single-slot payloads only carry a 5-bit length, longer
   // payloads are clamped to the multi-slot maximum.
   always_comb begin
      st_len = regi_pylenByte;
      if (BRss) begin
         st_len = {5'b0, regi_pylenByte[4:0]};
      end else if (regi_pylenByte > MAXLEN_L) begin
         st_len = MAXLEN_L;
      end
      st_nwords = 9'((11'(st_len) + 11'd3) >> 2);
      if (BRss) begin
         st_hdr = {8'b0, st_len[4:0], regi_FLOW, regi_LLID};
      end else begin
         st_hdr = {3'b0, st_len, regi_FLOW, regi_LLID};
      end
   end

   // Bookkeeping shared by the sequencer and the fetch side. nb is the bit
   // index that will be current after this cycle's advance; an arriving word
   // is placed relative to it so a late word still lines up with the stream.
   // Fetched words are counted against the word being consumed: at most the
   // current word and the next one may be held.
   always_comb begin
      busy      = (state == S_HDR) || (state == S_DATA);
      adv_data  = bit_adv_p && (state == S_DATA);
      nb        = bitcnt + {12'b0, adv_data};
      nb_word   = {1'b0, nb[12:5]};
      ack_ok    = txbuf_rd_ack && txbuf_rd_req && busy;
      want      = busy && (fetched < nwords) &&
                  (fetched < ({1'b0, bitcnt[12:5]} + 9'd2));
      data_last = ((bitcnt + 13'd1) == nbits);
      hdr_last  = hdr_short ? 4'd7 : 4'd15;
   end

   // Serial output: header bits, then data bits. A missing data word reads
   // as zeros.
   always_comb begin
      bufpacketin = 1'b0;
      case (state)
         S_HDR:   bufpacketin = hdr_shift[0];
         S_DATA:  bufpacketin = ws_valid & word_shift[0];
         default: bufpacketin = 1'b0;
      endcase
   end

   assign tx_busy = busy;

   // Main sequencer and fetch engine. A start pulse has priority over
   // everything else, so an acknowledge in the restart cycle is dropped and a
   // request that was pending goes low for one cycle before the new payload
   // starts fetching from address 0.
   always_ff @(posedge clk_6M) begin
      if (rst) begin
         state        <= S_IDLE;
         len_q        <= '0;
         nbits        <= '0;
         nwords       <= '0;
         hdr_shift    <= '0;
         hdr_cnt      <= '0;
         hdr_short    <= 1'b0;
         word_shift   <= '0;
         prefetch     <= '0;
         ws_valid     <= 1'b0;
         pf_valid     <= 1'b0;
         bitcnt       <= '0;
         fetched      <= '0;
         txbuf_rd_req <= 1'b0;
         txbuf_adr    <= '0;
         tx_done_p    <= 1'b0;
         tx_underrun  <= 1'b0;
      end else if (py_st_p) begin
         len_q        <= st_len;
         nbits        <= {st_len, 3'b000};
         nwords       <= st_nwords;
         hdr_shift    <= st_hdr;
         hdr_cnt      <= '0;
         hdr_short    <= BRss;
         ws_valid     <= 1'b0;
         pf_valid     <= 1'b0;
         bitcnt       <= '0;
         fetched      <= '0;
         txbuf_adr    <= '0;
         tx_underrun  <= 1'b0;
         txbuf_rd_req <= !txbuf_rd_req && (st_nwords != 9'd0);
         tx_done_p    <= !existpyheader && (st_len == 10'd0);
         if (existpyheader) begin
            state <= S_HDR;
         end else if (st_len == 10'd0) begin
            state <= S_IDLE;
         end else begin
            state <= S_DATA;
         end
      end else begin
         tx_done_p <= 1'b0;

         case (state)
            S_HDR: begin
               if (bit_adv_p) begin
                  hdr_shift <= {1'b0, hdr_shift[15:1]};
                  hdr_cnt   <= hdr_cnt + 4'd1;
                  if (hdr_cnt == hdr_last) begin
                     if (len_q == 10'd0) begin
                        state     <= S_DONE;
                        tx_done_p <= 1'b1;
                     end else begin
                        state <= S_DATA;
                     end
                  end
               end
            end
            S_DATA: begin
               if (bit_adv_p) begin
                  bitcnt <= bitcnt + 13'd1;
                  if (!ws_valid) begin
                     tx_underrun <= 1'b1;
                  end else if (bitcnt[4:0] == 5'd31) begin
                     word_shift <= prefetch;
                     ws_valid   <= pf_valid;
                     pf_valid   <= 1'b0;
                  end else begin
                     word_shift <= {1'b0, word_shift[31:1]};
                  end
                  if (data_last) begin
                     state     <= S_DONE;
                     tx_done_p <= 1'b1;
                  end
               end
            end
            S_DONE: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase

         // The arriving word is either the one being consumed (possibly
         // late, so it is pre-shifted to the current bit), the next one
         // (parked in prefetch), or one whose bits were all already sent as
         // underrun zeros (dropped).
         if (ack_ok) begin
            fetched      <= fetched + 9'd1;
            txbuf_adr    <= txbuf_adr + ADR_W'(1);
            txbuf_rd_req <= 1'b0;
            if (fetched == nb_word) begin
               word_shift <= txbuf_rdat >> nb[4:0];
               ws_valid   <= 1'b1;
            end else if (fetched == (nb_word + 9'd1)) begin
               prefetch <= txbuf_rdat;
               pf_valid <= 1'b1;
            end
         end else if (!busy) begin
            txbuf_rd_req <= 1'b0;
         end else if (!txbuf_rd_req) begin
            txbuf_rd_req <= want;
         end
      end
   end

endmodule

// File: tb/tb_txpybuf_rd.sv
// -----------------------------------------------------------------------------
// tb_txpybuf_rd
//
// Drives payloads into txpybuf_rd with a randomised buffer responder and
// random advance strobes. A behavioural model predicts each serial bit from
// the header rules and from when each buffer word was delivered.
// -----------------------------------------------------------------------------
module tb_txpybuf_rd;

   logic        clk_6M = 1'b0;
   logic        rst;
   logic        py_st_p;
   logic        bit_adv_p;
   logic        existpyheader;
   logic        BRss;
   logic [1:0]  regi_LLID;
   logic        regi_FLOW;
   logic [9:0]  regi_pylenByte;
   logic        txbuf_rd_req;
   logic [7:0]  txbuf_adr;
   logic        txbuf_rd_ack;
   logic [31:0] txbuf_rdat;
   logic        bufpacketin;
   logic        tx_busy;
   logic        tx_done_p;
   logic        tx_underrun;

   logic [31:0] memWords [256];
   int checkCount = 0;
   int errorCount = 0;

   txpybuf_rd #(.ADR_W(8), .MAXLEN(1021)) dut (
      .clk_6M         (clk_6M),
      .rst            (rst),
      .py_st_p        (py_st_p),
      .bit_adv_p      (bit_adv_p),
      .existpyheader  (existpyheader),
      .BRss           (BRss),
      .regi_LLID      (regi_LLID),
      .regi_FLOW      (regi_FLOW),
      .regi_pylenByte (regi_pylenByte),
      .txbuf_rd_req   (txbuf_rd_req),
      .txbuf_adr      (txbuf_adr),
      .txbuf_rd_ack   (txbuf_rd_ack),
      .txbuf_rdat     (txbuf_rdat),
      .bufpacketin    (bufpacketin),
      .tx_busy        (tx_busy),
      .tx_done_p      (tx_done_p),
      .tx_underrun    (tx_underrun)
   );

   // 6 MHz-ish clock; inputs change and outputs are sampled on the falling edge
   always #5 clk_6M = ~clk_6M;

   // Single comparison point for every check in the bench
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic fillMemory();
      for (int i = 0; i < 256; i++) memWords[i] = $urandom;
   endtask

   // Runs one payload from its start pulse. Called on a falling edge; drives
   // the start pulse in that cycle. Returns on a falling edge either two
   // cycles after the done pulse, or (abortBit >= 0) as soon as the data bit
   // index reaches abortBit while a read request is pending, leaving that
   // cycle's inputs idle for the caller.
   task automatic applyStimulus(input bit hdr, input bit brss, input logic [1:0] llid,
                                input bit flow, input logic [9:0] pylen,
                                input int minLat, input int maxLat, input int advPct,
                                input bit waitAck, input int abortBit, input bit ackAtStart);
      int lenM, nbitsM, nwordsM, hLen, hdrM;
      int phase, hIdx, bIdx, acks, ackCyc, doneCyc, limit, k;
      int ackAt [260];
      bit undM, busyM, expBit, avail, prevReq, finished;

      lenM    = brss ? int'(pylen & 10'd31) : ((pylen > 10'd1021) ? 1021 : int'(pylen));
      nbitsM  = lenM * 8;
      nwordsM = (lenM + 3) / 4;
      hLen    = brss ? 8 : 16;
      hdrM    = lenM * 8 + int'(flow) * 4 + int'(llid);
      limit   = 2000 + (hLen + nbitsM) * 4 * 100 / advPct;

      existpyheader  = hdr;
      BRss           = brss;
      regi_LLID      = llid;
      regi_FLOW      = flow;
      regi_pylenByte = pylen;
      py_st_p        = 1'b1;
      bit_adv_p      = 1'b0;
      txbuf_rd_ack   = ackAtStart;
      txbuf_rdat     = $urandom;
      prevReq        = txbuf_rd_req;
      @(negedge clk_6M);

      phase    = hdr ? 0 : ((lenM == 0) ? 2 : 1);
      busyM    = (phase != 2);
      doneCyc  = (phase == 2) ? 1 : -1;
      hIdx     = 0;
      bIdx     = 0;
      acks     = 0;
      ackCyc   = -1;
      undM     = 1'b0;
      finished = 1'b0;

      for (int n = 1; n < limit; n++) begin
         py_st_p      = 1'b0;
         bit_adv_p    = 1'b0;
         txbuf_rd_ack = 1'b0;

         if (n == 1) checkOutput("req_start", txbuf_rd_req, (!prevReq && nwordsM != 0));
         checkOutput("busy", tx_busy, busyM);
         checkOutput("done", tx_done_p, (n == doneCyc));
         checkOutput("underrun", tx_underrun, undM);

         avail = 1'b0;
         if (phase == 0) begin
            expBit = hdrM[hIdx];
         end else if (phase == 1) begin
            k      = bIdx / 32;
            avail  = (k < acks) && (ackAt[k] < n);
            expBit = avail ? memWords[k][bIdx % 32] : 1'b0;
         end else begin
            expBit = 1'b0;
         end
         checkOutput("bit", bufpacketin, expBit);
         if (acks >= nwordsM) checkOutput("extra_req", txbuf_rd_req, 0);

         if (n == doneCyc && !undM) checkOutput("reads", acks, nwordsM);
         if (doneCyc > 0 && n == doneCyc + 2) begin
            finished = 1'b1;
            break;
         end

         if (abortBit >= 0 && phase == 1 && bIdx >= abortBit && txbuf_rd_req) return;

         // Buffer responder: acknowledge each request after a random latency
         if (phase != 2) begin
            if (ackCyc == n) begin
               checkOutput("adr", txbuf_adr, acks % 256);
               txbuf_rd_ack = 1'b1;
               txbuf_rdat   = memWords[acks & 255];
               if (acks < 260) ackAt[acks] = n;
               acks++;
               ackCyc = -1;
            end else if (ackCyc < 0 && txbuf_rd_req) begin
               ackCyc = n + int'($urandom_range(maxLat, minLat));
            end
         end

         // Advance strobe; strobes after the payload ends must be ignored
         if (int'($urandom_range(99, 0)) < advPct &&
             !(waitAck && phase == 1 && !(acks > 0 && ackAt[0] < n))) begin
            bit_adv_p = 1'b1;
            if (phase == 0) begin
               hIdx++;
               if (hIdx == hLen) begin
                  if (lenM == 0) begin
                     phase   = 2;
                     doneCyc = n + 1;
                  end else begin
                     phase = 1;
                  end
               end
            end else if (phase == 1) begin
               if (!avail) undM = 1'b1;
               bIdx++;
               if (bIdx == nbitsM) begin
                  phase   = 2;
                  doneCyc = n + 1;
               end
            end
         end
         busyM = (phase != 2);
         @(negedge clk_6M);
      end

      if (!finished) begin
         checkOutput("timeout", 1, 0);
         py_st_p      = 1'b0;
         bit_adv_p    = 1'b0;
         txbuf_rd_ack = 1'b0;
      end
   endtask

   initial begin
      rst            = 1'b1;
      py_st_p        = 1'b0;
      bit_adv_p      = 1'b0;
      existpyheader  = 1'b0;
      BRss           = 1'b0;
      regi_LLID      = 2'd0;
      regi_FLOW      = 1'b0;
      regi_pylenByte = 10'd0;
      txbuf_rd_ack   = 1'b0;
      txbuf_rdat     = 32'd0;
      fillMemory();
      repeat (3) @(negedge clk_6M);

      checkOutput("rst_req", txbuf_rd_req, 0);
      checkOutput("rst_adr", txbuf_adr, 0);
      checkOutput("rst_bit", bufpacketin, 0);
      checkOutput("rst_busy", tx_busy, 0);
      checkOutput("rst_done", tx_done_p, 0);
      checkOutput("rst_undr", tx_underrun, 0);
      rst = 1'b0;
      @(negedge clk_6M);

      // Basic-rate header, three data bytes, two-cycle buffer latency
      memWords[0] = 32'h00CCBBAA;
      applyStimulus(1, 1, 2'd2, 1, 10'd3, 2, 2, 100, 0, -1, 0);

      // 16-bit header, three words, single-cycle latency
      applyStimulus(1, 0, 2'd1, 0, 10'd9, 1, 1, 70, 0, -1, 0);

      // Oversized length clamps to the multi-slot maximum
      fillMemory();
      applyStimulus(1, 0, 2'd3, 1, 10'd1023, 1, 4, 100, 0, -1, 0);

      // No header, advancing immediately against a slow buffer
      applyStimulus(0, 0, 2'd0, 0, 10'd4, 5, 5, 100, 0, -1, 0);
      checkOutput("undr_sticky", tx_underrun, 1);

      // Restart in the middle of an eight-word payload with a request pending;
      // an acknowledge in the restart cycle must be ignored
      fillMemory();
      applyStimulus(0, 0, 2'd1, 1, 10'd32, 3, 6, 100, 1, 40, 0);
      applyStimulus(1, 0, 2'd2, 0, 10'd12, 1, 3, 80, 0, -1, 1);

      // Zero-length payload with a basic-rate header
      applyStimulus(1, 1, 2'd1, 1, 10'd0, 1, 3, 100, 0, -1, 0);

      // Zero-length payload without a header
      applyStimulus(0, 0, 2'd0, 1, 10'd0, 1, 3, 100, 0, -1, 0);

      // Randomised payloads
      for (int r = 0; r < 16; r++) begin
         bit rHdr, rBr;
         logic [9:0] rLen;
         fillMemory();
         rHdr = 1'($urandom_range(1, 0));
         rBr  = 1'($urandom_range(1, 0));
         rLen = rBr ? 10'($urandom) : 10'($urandom_range(60, 0));
         applyStimulus(rHdr, rBr, 2'($urandom), 1'($urandom), rLen,
                       1, int'($urandom_range(8, 1)), int'($urandom_range(100, 20)),
                       !rHdr && ($urandom_range(1, 0) == 1), -1, 0);
      end

      // Reset in the middle of an underrunning payload
      applyStimulus(0, 0, 2'd0, 0, 10'd40, 10, 12, 100, 0, 20, 0);
      rst = 1'b1;
      @(negedge clk_6M);
      checkOutput("mid_rst_req", txbuf_rd_req, 0);
      checkOutput("mid_rst_adr", txbuf_adr, 0);
      checkOutput("mid_rst_bit", bufpacketin, 0);
      checkOutput("mid_rst_busy", tx_busy, 0);
      checkOutput("mid_rst_done", tx_done_p, 0);
      checkOutput("mid_rst_undr", tx_underrun, 0);
      rst = 1'b0;
      @(negedge clk_6M);
      applyStimulus(1, 0, 2'd1, 1, 10'd17, 1, 4, 90, 0, -1, 0);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
